// File: rtl/lcd_write_ctrl.sv
// HD44780-compatible 8-bit LCD write sequencer: power-on init, then user command/data writes.
// Optional LCD_LINE_WRAP_EN adds a 16x2 column tracker that auto-issues line-change commands.
module lcd_write_ctrl #(
   parameter int unsigned T_POWERUP_CYC = 1500000,
   parameter int unsigned T_SETUP_CYC   = 4,
   parameter int unsigned T_PULSE_CYC   = 50,
   parameter int unsigned T_HOLD_CYC    = 4,
   parameter int unsigned T_EXEC_CYC    = 4000,
   parameter int unsigned T_CLEAR_CYC   = 164000,
   parameter int unsigned TMR_W         = 21
) (
   input  logic       sysclk,
   input  logic       CLR,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_d,
   output logic       busy,
   output logic       init_done
);

   typedef enum logic [2:0] {
      StPwrWait,
      StInitLoad,
      StIdle,
      StSetup,
      StPulse,
      StHold,
      StExecWait
   } state_e;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [2:0]       init_idx_q, init_idx_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             init_done_q, init_done_d;
`ifdef LCD_LINE_WRAP_EN
   logic [4:0]       col_q, col_d;
`endif

   logic [TMR_W-1:0] phase_len;
   logic             phase_done;
   logic             is_slow_cmd;
   logic [7:0]       rom_byte;

   // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
   assign is_slow_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

   always_comb begin
      rom_byte = 8'h38;
      unique case (init_idx_q)
         3'd3:    rom_byte = 8'h0C;
         3'd4:    rom_byte = 8'h01;
         3'd5:    rom_byte = 8'h06;
         default: rom_byte = 8'h38;
      endcase
   end

   always_comb begin
      phase_len = TMR_W'(1);
      unique case (state_q)
         StPwrWait:  phase_len = TMR_W'(T_POWERUP_CYC);
         StSetup:    phase_len = TMR_W'(T_SETUP_CYC);
         StPulse:    phase_len = TMR_W'(T_PULSE_CYC);
         StHold:     phase_len = TMR_W'(T_HOLD_CYC);
         StExecWait: phase_len = is_slow_cmd ? TMR_W'(T_CLEAR_CYC) : TMR_W'(T_EXEC_CYC);
         default:    phase_len = TMR_W'(1);
      endcase
   end

   assign phase_done = (tmr_q == phase_len - TMR_W'(1));

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q + TMR_W'(1);
      init_idx_d  = init_idx_q;
      rs_d        = rs_q;
      data_d      = data_q;
      init_done_d = init_done_q;
`ifdef LCD_LINE_WRAP_EN
      col_d       = col_q;
`endif
      unique case (state_q)
         StPwrWait: if (phase_done) state_d = StInitLoad;
         StInitLoad: begin
            rs_d    = 1'b0;
            data_d  = rom_byte;
            state_d = StSetup;
         end
         StIdle: begin
            if (in_valid) begin
               rs_d    = in_rs;
               data_d  = in_data;
               state_d = StSetup;
`ifdef LCD_LINE_WRAP_EN
               if (!in_rs && (in_data == 8'h01 || in_data == 8'h02)) begin
                  col_d = 5'd0;
               end else if (!in_rs && in_data[7]) begin
                  col_d = {in_data[6], in_data[3:0]};
               end
`endif
            end
         end
         StSetup: if (phase_done) state_d = StPulse;
         StPulse: if (phase_done) state_d = StHold;
         StHold:  if (phase_done) state_d = StExecWait;
         StExecWait: begin
            if (phase_done) begin
               if (!init_done_q) begin
                  if (init_idx_q == 3'd5) begin
                     init_done_d = 1'b1;
                     state_d     = StIdle;
                  end else begin
                     init_idx_d = init_idx_q + 3'd1;
                     state_d    = StInitLoad;
                  end
               end else begin
                  state_d = StIdle;
`ifdef LCD_LINE_WRAP_EN
                  // End of a line: move the cursor ourselves before accepting more input.
                  if (rs_q && col_q == 5'd15) begin
                     col_d   = 5'd16;
                     rs_d    = 1'b0;
                     data_d  = 8'hC0;
                     state_d = StSetup;
                  end else if (rs_q && col_q == 5'd31) begin
                     col_d   = 5'd0;
                     rs_d    = 1'b0;
                     data_d  = 8'h80;
                     state_d = StSetup;
                  end else if (rs_q) begin
                     col_d = col_q + 5'd1;
                  end
`endif
               end
            end
         end
         default: state_d = StPwrWait;
      endcase
      if (state_d != state_q || state_q == StIdle) tmr_d = '0;
   end

   always_ff @(posedge sysclk) begin
      if (CLR) begin
         state_q     <= StPwrWait;
         tmr_q       <= '0;
         init_idx_q  <= 3'd0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         init_done_q <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
         col_q       <= 5'd0;
`endif
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         init_idx_q  <= init_idx_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
         init_done_q <= init_done_d;
`ifdef LCD_LINE_WRAP_EN
         col_q       <= col_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign lcd_e     = (state_q == StPulse);
   assign lcd_rs    = rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_d     = data_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed bench for lcd_write_ctrl with shortened timing; wrap checks follow LCD_LINE_WRAP_EN.
module tb_lcd_write_ctrl;

   localparam int unsigned TPwr   = 20;
   localparam int unsigned TSetup = 2;
   localparam int unsigned TPulse = 5;
   localparam int unsigned THold  = 2;
   localparam int unsigned TExec  = 10;
   localparam int unsigned TClear = 30;
   localparam int          Bound  = 2000;

   logic       sysclk = 1'b0;
   logic       CLR;
   logic       in_valid;
   logic       in_ready;
   logic       in_rs;
   logic [7:0] in_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_d;
   logic       busy;
   logic       init_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   lcd_write_ctrl #(
      .T_POWERUP_CYC(TPwr),
      .T_SETUP_CYC  (TSetup),
      .T_PULSE_CYC  (TPulse),
      .T_HOLD_CYC   (THold),
      .T_EXEC_CYC   (TExec),
      .T_CLEAR_CYC  (TClear),
      .TMR_W        (21)
   ) dut (
      .sysclk   (sysclk),
      .CLR      (CLR),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_rs    (in_rs),
      .in_data  (in_data),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_e    (lcd_e),
      .lcd_d    (lcd_d),
      .busy     (busy),
      .init_done(init_done)
   );

   typedef struct {
      logic       rs;
      logic [7:0] d;
      int         post;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Starting at a negedge: count low cycles before E, check the pulse and its payload,
   // then count low cycles until the next E (or until ready when to_ready is set).
   task automatic measure(input logic rs, input logic [7:0] d, input int pre, input int post,
                          input bit to_ready, input string nm);
      int n;
      n = 0;
      while (!lcd_e && n < Bound) begin
         n++;
         @(negedge sysclk);
      end
      check({nm, " setup"}, n, pre);
      check({nm, " rs"}, int'(lcd_rs), int'(rs));
      check({nm, " d"}, int'(lcd_d), int'(d));
      check({nm, " rw"}, int'(lcd_rw), 0);
      check({nm, " ready in pulse"}, int'(in_ready), 0);
      n = 0;
      while (lcd_e && n < Bound) begin
         n++;
         @(negedge sysclk);
      end
      check({nm, " pulse"}, n, int'(TPulse));
      check({nm, " hold d"}, int'(lcd_d), int'(d));
      n = 0;
      while (!lcd_e && !(to_ready && in_ready) && n < Bound) begin
         n++;
         @(negedge sysclk);
      end
      check({nm, " post"}, n, post);
   endtask

   task automatic accept(input logic rs, input logic [7:0] d, input string nm);
      check({nm, " ready"}, int'(in_ready), 1);
      in_valid = 1'b1;
      in_rs    = rs;
      in_data  = d;
      @(negedge sysclk);
      in_valid = 1'b0;
   endtask

   // Call at the first negedge after CLR has been dropped.
   task automatic run_init(input string nm);
      check({nm, " done low"}, int'(init_done), 0);
      measure(1'b0, 8'h38, 1 + TPwr + TSetup, THold + TExec + 1 + TSetup, 1'b0, {nm, " 38a"});
      measure(1'b0, 8'h38, 0, THold + TExec + 1 + TSetup, 1'b0, {nm, " 38b"});
      measure(1'b0, 8'h38, 0, THold + TExec + 1 + TSetup, 1'b0, {nm, " 38c"});
      measure(1'b0, 8'h0C, 0, THold + TExec + 1 + TSetup, 1'b0, {nm, " 0C"});
      measure(1'b0, 8'h01, 0, THold + TClear + 1 + TSetup, 1'b0, {nm, " 01"});
      measure(1'b0, 8'h06, 0, THold + TExec, 1'b1, {nm, " 06"});
      check({nm, " init_done"}, int'(init_done), 1);
      check({nm, " ready"}, int'(in_ready), 1);
      check({nm, " busy"}, int'(busy), 0);
   endtask

   initial begin
      int n;
      int t0;
      bit wrap;
`ifdef LCD_LINE_WRAP_EN
      wrap = 1'b1;
`else
      wrap = 1'b0;
`endif
      tbl[0] = '{rs: 1'b1, d: 8'h41, post: THold + TExec};
      tbl[1] = '{rs: 1'b0, d: 8'h01, post: THold + TClear};
      tbl[2] = '{rs: 1'b0, d: 8'h80, post: THold + TExec};
      tbl[3] = '{rs: 1'b0, d: 8'h02, post: THold + TClear};
      tbl[4] = '{rs: 1'b0, d: 8'h00, post: THold + TExec};
      tbl[5] = '{rs: 1'b0, d: 8'h04, post: THold + TExec};
      tbl[6] = '{rs: 1'b1, d: 8'h01, post: THold + TExec};
      tbl[7] = '{rs: 1'b1, d: 8'hFF, post: THold + TExec};

      in_valid = 1'b0;
      in_rs    = 1'b0;
      in_data  = 8'h00;
      CLR      = 1'b1;
      repeat (3) @(negedge sysclk);
      check("rst e", int'(lcd_e), 0);
      check("rst rs", int'(lcd_rs), 0);
      check("rst rw", int'(lcd_rw), 0);
      check("rst d", int'(lcd_d), 0);
      check("rst ready", int'(in_ready), 0);
      check("rst busy", int'(busy), 1);
      check("rst init_done", int'(init_done), 0);
      CLR = 1'b0;
      run_init("init");

      for (int i = 0; i < 8; i++) begin
         accept(tbl[i].rs, tbl[i].d, $sformatf("vec%0d", i));
         measure(tbl[i].rs, tbl[i].d, TSetup, tbl[i].post, 1'b1, $sformatf("vec%0d", i));
      end

      // Back-to-back with in_valid held high.
      check("b2b ready", int'(in_ready), 1);
      in_valid = 1'b1;
      in_rs    = 1'b1;
      in_data  = 8'h48;
      t0       = cyc;
      @(negedge sysclk);
      in_data = 8'h49;
      measure(1'b1, 8'h48, TSetup, THold + TExec, 1'b1, "b2b first");
      check("b2b spacing", cyc - t0, 1 + TSetup + TPulse + THold + TExec);
      @(negedge sysclk);
      in_valid = 1'b0;
      measure(1'b1, 8'h49, TSetup, THold + TExec, 1'b1, "b2b second");

      // Reset in the middle of an E pulse.
      accept(1'b1, 8'h55, "midrst");
      n = 0;
      while (!lcd_e && n < Bound) begin
         n++;
         @(negedge sysclk);
      end
      check("midrst reach pulse", int'(lcd_e), 1);
      CLR = 1'b1;
      @(negedge sysclk);
      check("midrst e", int'(lcd_e), 0);
      check("midrst init_done", int'(init_done), 0);
      check("midrst busy", int'(busy), 1);
      check("midrst ready", int'(in_ready), 0);
      CLR = 1'b0;
      run_init("reinit");

      // Sixteen characters then a seventeenth; line wrap inserts 0xC0 in between.
      for (int i = 0; i < 16; i++) begin
         accept(1'b1, 8'h61 + 8'(i), $sformatf("col%0d", i));
         measure(1'b1, 8'h61 + 8'(i), TSetup,
                 (wrap && i == 15) ? THold + TExec + TSetup : THold + TExec, 1'b1,
                 $sformatf("col%0d", i));
      end
      if (wrap) measure(1'b0, 8'hC0, 0, THold + TExec, 1'b1, "wrap cmd");
      accept(1'b1, 8'h71, "col16");
      measure(1'b1, 8'h71, TSetup, THold + TExec, 1'b1, "col16");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
